// File: rtl/exec_mem_stage_if.sv
// Execute-to-memory stage bundle: execute-side instruction fields in, condition result,
// flags and memory-stage pipeline register contents out.
interface exec_mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    // Handshake: in_valid qualifies the execute-side fields in the cycle it is high; there is
    // no ready. The stage accepts on every edge unless stall holds it or flush kills it.
    // valid_m marks the registered memory-stage slot.
    logic              in_valid;
    logic [3:0]        cond;
    logic [1:0]        flag_write;
    logic              reg_write_e;
    logic              mem_write_e;
    logic              mem_to_reg_e;
    logic              pc_src_e;
    logic [3:0]        wa3_e;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data_e;
    logic [3:0]        alu_flags;
    logic              stall;
    logic              flush;

    logic              cond_ex;
    logic [3:0]        flags;
    logic              valid_m;
    logic              reg_write_m;
    logic              mem_write_m;
    logic              mem_to_reg_m;
    logic              pc_src_m;
    logic [3:0]        wa3_m;
    logic [DATA_W-1:0] alu_result_m;
    logic [DATA_W-1:0] write_data_m;
    logic [CNT_W-1:0]  exec_count;
    logic [CNT_W-1:0]  skip_count;

    modport master (
        output in_valid, cond, flag_write, reg_write_e, mem_write_e, mem_to_reg_e, pc_src_e,
               wa3_e, alu_result, write_data_e, alu_flags, stall, flush,
        input  cond_ex, flags, valid_m, reg_write_m, mem_write_m, mem_to_reg_m, pc_src_m,
               wa3_m, alu_result_m, write_data_m, exec_count, skip_count
    );

    modport slave (
        input  in_valid, cond, flag_write, reg_write_e, mem_write_e, mem_to_reg_e, pc_src_e,
               wa3_e, alu_result, write_data_e, alu_flags, stall, flush,
        output cond_ex, flags, valid_m, reg_write_m, mem_write_m, mem_to_reg_m, pc_src_m,
               wa3_m, alu_result_m, write_data_m, exec_count, skip_count
    );
endinterface

// File: rtl/exec_mem_stage.sv
// ARM condition check, NZCV flag register and execute->memory pipeline register.
// Optional EXEC_STATS_EN adds executed/skipped instruction counters.
module exec_mem_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              rst_n,
    exec_mem_stage_if.slave  bus
);
    logic [3:0]        flags_q, flags_d;
    logic              valid_q, reg_write_q, mem_write_q, mem_to_reg_q, pc_src_q;
    logic [3:0]        wa3_q;
    logic [DATA_W-1:0] alu_result_q, write_data_q;
    logic              n_f, z_f, c_f, v_f;
    logic              pass;
    logic              cond_ex;
    logic              advance;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    // Decode looks only at the registered flags; alu_flags of the same instruction never bypass.
    always_comb begin
        pass = 1'b1;
        case (bus.cond)
            4'b0000: pass = z_f;
            4'b0001: pass = !z_f;
            4'b0010: pass = c_f;
            4'b0011: pass = !c_f;
            4'b0100: pass = n_f;
            4'b0101: pass = !n_f;
            4'b0110: pass = v_f;
            4'b0111: pass = !v_f;
            4'b1000: pass = c_f && !z_f;
            4'b1001: pass = !c_f || z_f;
            4'b1010: pass = (n_f == v_f);
            4'b1011: pass = (n_f != v_f);
            4'b1100: pass = !z_f && (n_f == v_f);
            4'b1101: pass = z_f || (n_f != v_f);
            default: pass = 1'b1;
        endcase
    end

    assign cond_ex = bus.in_valid && pass;
    assign advance = !bus.stall && !bus.flush;

    always_comb begin
        flags_d = flags_q;
        if (advance && cond_ex) begin
            if (bus.flag_write[1]) flags_d[3:2] = bus.alu_flags[3:2];
            if (bus.flag_write[0]) flags_d[1:0] = bus.alu_flags[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q      <= '0;
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            pc_src_q     <= 1'b0;
            wa3_q        <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
        end else if (bus.flush) begin
            // Kill the slot but leave data registers as they were; flags are not touched.
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            pc_src_q     <= 1'b0;
        end else if (!bus.stall) begin
            flags_q      <= flags_d;
            valid_q      <= bus.in_valid;
            reg_write_q  <= bus.reg_write_e && cond_ex;
            mem_write_q  <= bus.mem_write_e && cond_ex;
            pc_src_q     <= bus.pc_src_e && cond_ex;
            mem_to_reg_q <= bus.mem_to_reg_e;
            wa3_q        <= bus.wa3_e;
            alu_result_q <= bus.alu_result;
            write_data_q <= bus.write_data_e;
        end
    end

`ifdef EXEC_STATS_EN
    logic [CNT_W-1:0] exec_cnt_q, skip_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_cnt_q <= '0;
            skip_cnt_q <= '0;
        end else if (advance) begin
            if (cond_ex)
                exec_cnt_q <= exec_cnt_q + 1'b1;
            else if (bus.in_valid)
                skip_cnt_q <= skip_cnt_q + 1'b1;
        end
    end

    assign bus.exec_count = exec_cnt_q;
    assign bus.skip_count = skip_cnt_q;
`else
    assign bus.exec_count = '0;
    assign bus.skip_count = '0;
`endif

    assign bus.cond_ex      = cond_ex;
    assign bus.flags        = flags_q;
    assign bus.valid_m      = valid_q;
    assign bus.reg_write_m  = reg_write_q;
    assign bus.mem_write_m  = mem_write_q;
    assign bus.mem_to_reg_m = mem_to_reg_q;
    assign bus.pc_src_m     = pc_src_q;
    assign bus.wa3_m        = wa3_q;
    assign bus.alu_result_m = alu_result_q;
    assign bus.write_data_m = write_data_q;
endmodule

// File: tb/tb_exec_mem_stage.sv
// Bench for exec_mem_stage: reference model feeds an expected-output queue on every edge.
module tb_exec_mem_stage;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int W      = 5 + 4 + 2*DATA_W + 4 + 2*CNT_W;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [W-1:0] exp_q[$];

    // reference model state
    logic              m_valid, m_rw, m_mw, m_mtr, m_pcs;
    logic [3:0]        m_wa3, m_flags;
    logic [DATA_W-1:0] m_alu, m_wd;
    logic [CNT_W-1:0]  m_exec, m_skip;

    exec_mem_stage_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    exec_mem_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    // Base condition selected by cond[3:1], inverted by cond[0]; 111x always passes.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, b;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cy;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cy & ~z;
            3'd5: b = ~(n ^ v);
            3'd6: b = ~z & ~(n ^ v);
            default: b = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return 1'b1;
        return c[0] ? ~b : b;
    endfunction

    function automatic logic [W-1:0] exp_vec();
        return {m_valid, m_rw, m_mw, m_mtr, m_pcs, m_wa3, m_alu, m_wd, m_flags, m_exec, m_skip};
    endfunction

    function automatic logic [W-1:0] obs_vec();
        return {bus.valid_m, bus.reg_write_m, bus.mem_write_m, bus.mem_to_reg_m, bus.pc_src_m,
                bus.wa3_m, bus.alu_result_m, bus.write_data_m, bus.flags,
                bus.exec_count, bus.skip_count};
    endfunction

    task automatic model_reset();
        {m_valid, m_rw, m_mw, m_mtr, m_pcs} = '0;
        m_wa3 = '0; m_flags = '0; m_alu = '0; m_wd = '0; m_exec = '0; m_skip = '0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic ce;
        ce = bus.in_valid && cond_pass(bus.cond, m_flags);
        if (bus.flush) begin
            {m_valid, m_rw, m_mw, m_mtr, m_pcs} = '0;
        end else if (!bus.stall) begin
            m_valid = bus.in_valid;
            m_rw    = bus.reg_write_e & ce;
            m_mw    = bus.mem_write_e & ce;
            m_pcs   = bus.pc_src_e & ce;
            m_mtr   = bus.mem_to_reg_e;
            m_wa3   = bus.wa3_e;
            m_alu   = bus.alu_result;
            m_wd    = bus.write_data_e;
            if (ce && bus.flag_write[1]) m_flags[3:2] = bus.alu_flags[3:2];
            if (ce && bus.flag_write[0]) m_flags[1:0] = bus.alu_flags[1:0];
`ifdef EXEC_STATS_EN
            if (ce) m_exec = m_exec + 1'b1;
            else if (bus.in_valid) m_skip = m_skip + 1'b1;
`endif
        end
        exp_q.push_back(exp_vec());
    endtask

    // ---------------- driver ----------------
    task automatic set_in(input logic v, input logic [3:0] c, input logic [1:0] fw,
                          input logic rw, input logic mw, input logic mtr, input logic pcs,
                          input logic [3:0] wa3, input logic [DATA_W-1:0] alu,
                          input logic [DATA_W-1:0] wd, input logic [3:0] af,
                          input logic st, input logic fl);
        bus.in_valid = v;  bus.cond = c; bus.flag_write = fw;
        bus.reg_write_e = rw; bus.mem_write_e = mw; bus.mem_to_reg_e = mtr; bus.pc_src_e = pcs;
        bus.wa3_e = wa3; bus.alu_result = alu; bus.write_data_e = wd; bus.alu_flags = af;
        bus.stall = st; bus.flush = fl;
    endtask

    task automatic set_random();
        set_in(1'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom, 4'($urandom),
               1'($urandom), 1'($urandom));
    endtask

    // model the edge, clock the DUT, land 1 time unit after the edge
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [W-1:0] got, exp;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            set_random();
            @(posedge clk);
            #1;
            got = obs_vec();
            checks++;
            if (got !== '0) begin
                failures++;
                $display("FAIL reset_hold got=%h exp=0", got);
            end
        end
        rst_n = 1'b1;
        set_in(1, 4'hE, 2'b00, 1, 0, 0, 0, 4'd5, 32'h12345678, 32'h0, 4'h0, 0, 0);
        tick();
        got = obs_vec();
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_first_advance got=%h exp=%h", got, exp);
        end
        checks++;
        if ({bus.reg_write_m, bus.wa3_m, bus.alu_result_m} !== {1'b1, 4'd5, 32'h12345678}) begin
            failures++;
            $display("FAIL reset_first_fields got=%b/%0d/%h exp=1/5/12345678",
                     bus.reg_write_m, bus.wa3_m, bus.alu_result_m);
        end
    endtask

    task automatic test_flag_chain();
        logic [W-1:0] got, exp;
        set_in(1, 4'hE, 2'b11, 0, 0, 0, 0, 4'd1, 32'h0, 32'h0, 4'b0100, 0, 0);  // SUBS -> Z
        tick();
        set_in(1, 4'h0, 2'b00, 1, 0, 0, 0, 4'd2, 32'hAA, 32'h0, 4'b0000, 0, 0);  // EQ passes
        tick();
        set_in(1, 4'h1, 2'b11, 1, 1, 0, 1, 4'd3, 32'hBB, 32'hCC, 4'b1011, 0, 0);  // NE fails
        tick();
        for (int i = 0; i < 3; i++) begin
            got = (i == 2) ? obs_vec() : '0;
            exp = exp_q.pop_front();
            if (i == 2) begin
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL flag_chain_ne got=%h exp=%h", got, exp);
                end
            end
        end
        checks++;
        if ({bus.valid_m, bus.reg_write_m, bus.flags} !== {1'b1, 1'b0, 4'b0100}) begin
            failures++;
            $display("FAIL flag_chain_ne_fields got=%b%b_%b exp=10_0100",
                     bus.valid_m, bus.reg_write_m, bus.flags);
        end
    endtask

    task automatic test_partial_update();
        logic [W-1:0] got, exp;
        set_in(1, 4'hE, 2'b11, 0, 0, 0, 0, 4'd0, 32'h1, 32'h0, 4'b1111, 0, 0);
        tick();
        got = obs_vec(); exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL partial_set got=%h exp=%h", got, exp);
        end
        set_in(1, 4'hE, 2'b10, 0, 0, 0, 0, 4'd0, 32'h2, 32'h0, 4'b0000, 0, 0);
        tick();
        got = obs_vec(); exp = exp_q.pop_front();
        checks++;
        if (got !== exp || bus.flags !== 4'b0011) begin
            failures++;
            $display("FAIL partial_nz flags=%b exp=0011 got=%h exp=%h", bus.flags, got, exp);
        end
    endtask

    task automatic test_stall_flush();
        logic [W-1:0] got, exp;
        set_in(1, 4'hE, 2'b11, 1, 1, 1, 0, 4'd9, 32'hDEAD0001, 32'hBEEF0001, 4'b1010, 0, 0);
        tick();
        void'(exp_q.pop_front());
        for (int i = 0; i < 3; i++) begin
            set_in(1, 4'hE, 2'b11, 1, 1, 1, 1, 4'($urandom), $urandom, $urandom, 4'b0101, 1, 0);
            tick();
            got = obs_vec(); exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL stall_hold%0d got=%h exp=%h", i, got, exp);
            end
        end
        set_in(1, 4'hE, 2'b11, 1, 1, 0, 1, 4'd3, 32'h5, 32'h6, 4'b0101, 1, 1);
        tick();
        got = obs_vec(); exp = exp_q.pop_front();
        checks++;
        if (got !== exp || {bus.valid_m, bus.mem_write_m, bus.flags} !== 6'b00_1010) begin
            failures++;
            $display("FAIL flush_stall got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_cond_sweep();
        logic [W-1:0] got, exp;
        for (int p = 0; p < 16; p++) begin
            set_in(1, 4'hE, 2'b11, 0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 4'(p), 0, 0);
            tick();
            got = obs_vec(); exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL sweep_set%0d got=%h exp=%h", p, got, exp);
            end
            for (int c = 0; c < 16; c++) begin
                bus.cond = 4'(c);
                bus.in_valid = 1'b1;
                #1;
                checks++;
                if (bus.cond_ex !== cond_pass(4'(c), 4'(p))) begin
                    failures++;
                    $display("FAIL cond_ex cond=%h flags=%h got=%b", c, p, bus.cond_ex);
                end
            end
            bus.in_valid = 1'b0;
            bus.cond = 4'hE;
            #1;
            checks++;
            if (bus.cond_ex !== 1'b0) begin
                failures++;
                $display("FAIL cond_ex_bubble flags=%h got=%b exp=0", p, bus.cond_ex);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got, exp;
        for (int i = 0; i < 60; i++) begin
            set_random();
            bus.stall = ($urandom_range(0, 7) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            #1;
            checks++;
            if (bus.cond_ex !== (bus.in_valid && cond_pass(bus.cond, m_flags))) begin
                failures++;
                $display("FAIL b2b_cond_ex%0d got=%b", i, bus.cond_ex);
            end
            tick();
            got = obs_vec(); exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL b2b_out%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        set_in(1, 4'hE, 2'b11, 1, 1, 1, 1, 4'd7, 32'h77, 32'h88, 4'b1111, 0, 0);
        tick();
        void'(exp_q.pop_front());
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== '0) begin
            failures++;
            $display("FAIL reset_async got=%h exp=0", obs_vec());
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_stats();
        logic [W-1:0] got, exp;
        // flags are 0000 after reset, so EQ fails
        for (int i = 0; i < 16; i++) begin
            if (i < 10)      set_in(1, 4'hE, 2'b00, 1, 0, 0, 0, 4'd1, 32'(i), 32'h0, 4'hF, 0, 0);
            else if (i < 14) set_in(1, 4'h0, 2'b00, 1, 0, 0, 0, 4'd1, 32'(i), 32'h0, 4'hF, 0, 0);
            else             set_in(0, 4'hE, 2'b00, 1, 0, 0, 0, 4'd1, 32'(i), 32'h0, 4'hF, 0, 0);
            tick();
            got = obs_vec(); exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL stats_seq%0d got=%h exp=%h", i, got, exp);
            end
        end
`ifdef EXEC_STATS_EN
        checks++;
        if ({bus.exec_count, bus.skip_count} !== {16'd10, 16'd4}) begin
            failures++;
            $display("FAIL stats_counts exec=%0d skip=%0d exp=10/4", bus.exec_count, bus.skip_count);
        end
        set_in(1, 4'hE, 2'b00, 0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 4'h0, 0, 0);
        for (int i = 0; i < 65535 - 10; i++) begin
            tick();
            got = obs_vec(); exp = exp_q.pop_front();
            if (got !== exp) begin
                checks++;
                failures++;
                $display("FAIL stats_ramp%0d got=%h exp=%h", i, got, exp);
                break;
            end
        end
        checks++;
        if (bus.exec_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL stats_preload got=%h exp=ffff", bus.exec_count);
        end
        tick();
        void'(exp_q.pop_front());
        checks++;
        if ({bus.exec_count, bus.skip_count} !== {16'h0, 16'd4}) begin
            failures++;
            $display("FAIL stats_wrap got=%h/%h exp=0000/0004", bus.exec_count, bus.skip_count);
        end
`else
        checks++;
        if ({bus.exec_count, bus.skip_count} !== 32'h0) begin
            failures++;
            $display("FAIL stats_tied got=%h/%h exp=0/0", bus.exec_count, bus.skip_count);
        end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        set_in(0, 4'hE, 2'b00, 0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 4'h0, 0, 0);
        model_reset();
        #1;
        test_reset();
        test_flag_chain();
        test_partial_update();
        test_stall_flush();
        test_cond_sweep();
        test_back_to_back();
        test_reset_mid_stall();
        test_stats();
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/exec_mem_stage.md
# exec_mem_stage

Condition-evaluation and pipeline-register stage directly downstream of the execute datapath. It holds the architectural NZCV flag register and checks each instruction's ARM condition field against it. It gates register and memory write enables, updates flags from the ALU result, and registers the result, store data and control into the memory stage, with stall and flush control.

## Interface
Parameters:
- DATA_W, 32, width of ALU result and store data
- CNT_W, 16, width of statistics counters (used only with EXEC_STATS_EN)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute stage holds a valid instruction
- cond  in  4  ARM condition field, instr[31:28]
- flag_write  in  2  [1] update N,Z; [0] update C,V
- reg_write_e, mem_write_e, mem_to_reg_e, pc_src_e  in  1 each  decoded control
- wa3_e  in  4  destination register
- alu_result  in  DATA_W  ALU output
- write_data_e  in  DATA_W  store data (RD2)
- alu_flags  in  4  {N,Z,C,V} = [3],[2],[1],[0]
- stall  in  1  hold all stage state
- flush  in  1  kill the instruction entering this stage
- cond_ex  out  1  combinational: in_valid and condition passes against registered flags
- flags  out  4  registered NZCV, same bit order as alu_flags
- valid_m  out  1  memory-stage instruction valid
- reg_write_m, mem_write_m, mem_to_reg_m, pc_src_m  out  1 each  gated control
- wa3_m  out  4
- alu_result_m, write_data_m  out  DATA_W
- exec_count, skip_count  out  CNT_W  statistics (zero without EXEC_STATS_EN)

## Operation
- Condition decode (uses flags register, never alu_flags): 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 treated as 1.
- Advance, when !stall and !flush: valid_m<=in_valid; reg_write_m, mem_write_m, pc_src_m <= control AND cond_ex; mem_to_reg_m, wa3_m, alu_result_m, write_data_m captured unconditionally.
- Flag update only on advance with cond_ex=1: flags[3:2]<=alu_flags[3:2] if flag_write[1]; flags[1:0]<=alu_flags[1:0] if flag_write[0]; untouched bits hold.
- flush (priority over stall): valid_m, reg_write_m, mem_write_m, pc_src_m, mem_to_reg_m <= 0; data registers hold; flags not updated.
- stall without flush: every register holds, including flags and counters.
- in_valid=0 on advance: bubble; cond_ex=0, so gated controls are 0 and flags unchanged.

## Timing
- Latency 1 cycle from execute inputs to *_m outputs; cond_ex is combinational from flags and cond.
- Back-to-back flag dependency: the flag write from instruction i is visible to cond_ex of instruction i+1 in the next cycle; no bypass needed.
- Reset (rst_n=0, asynchronous): flags=0000, valid_m=0, all control outputs 0, wa3_m=0, alu_result_m=0, write_data_m=0, counters 0. First edge after release behaves as a normal advance.
- Reset asserted mid-stall or mid-flush: reset wins immediately.

## Configuration
- EXEC_STATS_EN defined: exec_count increments on each advance with cond_ex=1; skip_count increments on each advance with in_valid=1 and cond_ex=0. Both hold on stall/flush, wrap from all-ones to 0, and reset to 0.
- Not defined: no counter registers; exec_count and skip_count tied to 0.

## Test plan
- Reset: hold rst_n=0 with random inputs -> flags=0000, valid_m=0, all controls 0; release and apply AL reg_write_e=1, wa3_e=5, alu_result=0x12345678 -> next cycle reg_write_m=1, wa3_m=5, alu_result_m=0x12345678.
- Flag chain: SUBS with alu_flags=0100, flag_write=11 -> flags=0100; next EQ, reg_write_e=1 -> reg_write_m=1; NE instead -> reg_write_m=0 with valid_m=1, flags unchanged.
- Partial update: flags=1111, flag_write=10, alu_flags=0000 -> flags=0011.
- Stall/flush: stall=1 for 3 cycles -> all outputs and flags frozen; flush=1 together with stall and mem_write_e=1 -> valid_m=0, mem_write_m=0, flags unchanged.
- Full condition sweep: every cond value against all 16 flag patterns -> cond_ex matches the decode list; 1111 always 1.
- EXEC_STATS_EN: 10 passing plus 4 failing valid instructions and 2 bubbles -> exec_count=10, skip_count=4; preload to 0xFFFF and pass one -> exec_count=0.
